// File: rtl/addsub_seq_pkg.sv
// Shared types for the slice-serial mantissa adder/subtractor.
// The FSM states and operation codes are used by the RTL and by the testbench.
package adder_pkg;

    typedef enum logic [1:0] {
        ADD_IDLE,
        ADD_SLICE,
        ADD_NEG,
        ADD_DONE
    } AddSeqState;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_ABSDIFF = 2'd2
    } AddOp;

    // SUB and ABSDIFF both add ~B with carry-in 1; the reserved code runs as ADD.
    function automatic logic is_sub_op(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_ABSDIFF);
    endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// REQ/ACK request bus between the FPU alignment/normalise stages and addsub_seq.
interface addsub_seq_if #(
    parameter int WIDTH = 24
);
    logic             REQ;
    logic [1:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Z;
    logic             COUT;
    logic             SWAP;
    logic             ZERO;
    logic             ACK;
    logic             BUSY;

    modport master (
        output REQ, OP, A, B,
        input  Z, COUT, SWAP, ZERO, ACK, BUSY
    );

    modport slave (
        input  REQ, OP, A, B,
        output Z, COUT, SWAP, ZERO, ACK, BUSY
    );
endinterface

// File: rtl/slice_adder.sv
// Combinational SLICE-bit adder with carry in/out.
// It is shared between the add pass and the negate pass.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq.sv
// Slice-serial mantissa add/sub/absdiff: processes SLICE bits per cycle.
// An optional negate pass produces |A-B|, and the results are registered and held.
module addsub_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SLICE = 8
) (
    input  logic         CLK,
    input  logic         RSTN,
    addsub_seq_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE + 1);

    if (WIDTH % SLICE != 0) begin : g_width_check
        $error("addsub_seq: WIDTH must be a multiple of SLICE");
    end

    AddSeqState       state, next_state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             is_absdiff;
    logic [WIDTH-1:0] a_q, b_q, r, r_next;
    logic [WIDTH-1:0] z_q;
    logic             cout_q, swap_q, zero_q;
    logic [SLICE-1:0] sx, sy, ssum;
    logic             scout;
    logic             last;
    int               base;

    slice_adder #(.SLICE(SLICE)) u_slice (
        .x    (sx),
        .y    (sy),
        .cin  (carry),
        .sum  (ssum),
        .cout (scout)
    );

    // The negate pass feeds ~R into the same adder; carry was preset to 1 on entry.
    always_comb begin
        next_state = state;
        base       = int'(cnt) * SLICE;
        last       = (int'(cnt) == NSLICE - 1);
        sx         = a_q[base +: SLICE];
        sy         = b_q[base +: SLICE];
        if (state == ADD_NEG) begin
            sx = ~r[base +: SLICE];
            sy = '0;
        end
        r_next              = r;
        r_next[base +: SLICE] = ssum;

        case (state)
            ADD_IDLE:  if (bus.REQ) next_state = ADD_SLICE;
            ADD_SLICE: if (last) next_state = (is_absdiff && !scout) ? ADD_NEG : ADD_DONE;
            ADD_NEG:   if (last) next_state = ADD_DONE;
            ADD_DONE:  next_state = ADD_IDLE;
            default:   next_state = ADD_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state      <= ADD_IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            is_absdiff <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            r          <= '0;
            z_q        <= '0;
            cout_q     <= 1'b0;
            swap_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ADD_IDLE: begin
                    if (bus.REQ) begin
                        a_q        <= bus.A;
                        b_q        <= is_sub_op(bus.OP) ? ~bus.B : bus.B;
                        carry      <= is_sub_op(bus.OP);
                        is_absdiff <= (bus.OP == OP_ABSDIFF);
                        cnt        <= '0;
                        r          <= '0;
                    end
                end
                ADD_SLICE: begin
                    r     <= r_next;
                    carry <= scout;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last && next_state == ADD_NEG) carry <= 1'b1;
                end
                ADD_NEG: begin
                    r     <= r_next;
                    carry <= scout;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase

            // A negate pass only follows a zero final carry, so COUT is 0 on that path.
            if (next_state == ADD_DONE && state != ADD_DONE) begin
                z_q    <= r_next;
                cout_q <= (state == ADD_SLICE) ? scout : 1'b0;
                swap_q <= (state == ADD_NEG);
                zero_q <= (r_next == '0);
            end
        end
    end

    assign bus.Z    = z_q;
    assign bus.COUT = cout_q;
    assign bus.SWAP = swap_q;
    assign bus.ZERO = zero_q;
    assign bus.ACK  = (state == ADD_DONE);
    assign bus.BUSY = (state != ADD_IDLE);

endmodule

// File: tb/tb_addsub_seq.sv
// Directed testbench for addsub_seq: a 24/8 instance for the main checks.
// A 32/32 instance covers back-to-back requests with REQ held high.
module tb_addsub_seq;
    import adder_pkg::*;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    addsub_seq_if #(.WIDTH(24)) bus ();
    addsub_seq_if #(.WIDTH(32)) bus32 ();

    addsub_seq #(.WIDTH(24), .SLICE(8)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.slave)
    );

    addsub_seq #(.WIDTH(32), .SLICE(32)) dut32 (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus32.slave)
    );

    int          errors = 0;
    int          checks = 0;
    int          lat;
    logic        busy_ok, ack_after, busy_after;
    logic [23:0] z_ack;
    logic        cout_ack, swap_ack, zero_ack;
    logic        ack_any, busy_any, held;
    logic [7:0]  ack_seen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request, then waits (bounded) for ACK and samples the cycle after it.
    task automatic applyStimulus(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.OP  = op;
        bus.A   = a;
        bus.B   = b;
        @(posedge CLK);
        #1;
        bus.REQ = 1'b0;
        bus.OP  = 2'b00;
        bus.A   = '0;
        bus.B   = '0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) busy_ok = 1'b0;
            if (bus.ACK) begin
                lat      = i;
                z_ack    = bus.Z;
                cout_ack = bus.COUT;
                swap_ack = bus.SWAP;
                zero_ack = bus.ZERO;
                break;
            end
        end
        @(negedge CLK);
        ack_after  = bus.ACK;
        busy_after = bus.BUSY;
    endtask

    initial begin
        bus.REQ   = 1'b0;
        bus.OP    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus32.REQ = 1'b0;
        bus32.OP  = 2'b00;
        bus32.A   = '0;
        bus32.B   = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;

        ack_any  = 1'b0;
        busy_any = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            ack_any  = ack_any | bus.ACK;
            busy_any = busy_any | bus.BUSY;
        end
        checkOutput("reset_z", 32'(bus.Z), 32'h0);
        checkOutput("reset_flags", {29'd0, bus.COUT, bus.SWAP, bus.ZERO}, 32'h0);
        checkOutput("reset_ack", 32'(ack_any), 32'h0);
        checkOutput("reset_busy", 32'(busy_any), 32'h0);

        applyStimulus(OP_ADD, 24'hFFFFFF, 24'h000001);
        checkOutput("add_ovf_lat", 32'(lat), 32'd4);
        checkOutput("add_ovf_z", 32'(z_ack), 32'h0);
        checkOutput("add_ovf_cout", 32'(cout_ack), 32'h1);
        checkOutput("add_ovf_zero", 32'(zero_ack), 32'h1);
        checkOutput("add_ovf_swap", 32'(swap_ack), 32'h0);
        checkOutput("add_ovf_ack_pulse", 32'(ack_after), 32'h0);
        checkOutput("add_ovf_idle_after", 32'(busy_after), 32'h0);
        checkOutput("add_ovf_busy", 32'(busy_ok), 32'h1);

        applyStimulus(OP_ADD, 24'h00FF80, 24'h000080);
        checkOutput("add_chain_z", 32'(z_ack), 32'h010000);
        checkOutput("add_chain_cout", 32'(cout_ack), 32'h0);
        checkOutput("add_chain_zero", 32'(zero_ack), 32'h0);

        applyStimulus(OP_SUB, 24'h000010, 24'h000001);
        checkOutput("sub_lat", 32'(lat), 32'd4);
        checkOutput("sub_z", 32'(z_ack), 32'h00000F);
        checkOutput("sub_cout", 32'(cout_ack), 32'h1);
        checkOutput("sub_swap", 32'(swap_ack), 32'h0);
        held = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            if (bus.Z !== 24'h00000F || bus.COUT !== 1'b1 || bus.SWAP !== 1'b0 ||
                bus.ZERO !== 1'b0 || bus.ACK !== 1'b0) held = 1'b0;
        end
        checkOutput("sub_hold", 32'(held), 32'h1);

        applyStimulus(OP_SUB, 24'h000001, 24'h000002);
        checkOutput("sub_neg_z", 32'(z_ack), 32'hFFFFFF);
        checkOutput("sub_neg_cout", 32'(cout_ack), 32'h0);
        checkOutput("sub_neg_swap", 32'(swap_ack), 32'h0);

        applyStimulus(OP_ABSDIFF, 24'h000001, 24'h000010);
        checkOutput("absd_swap_lat", 32'(lat), 32'd7);
        checkOutput("absd_swap_z", 32'(z_ack), 32'h00000F);
        checkOutput("absd_swap_swap", 32'(swap_ack), 32'h1);
        checkOutput("absd_swap_cout", 32'(cout_ack), 32'h0);
        checkOutput("absd_swap_zero", 32'(zero_ack), 32'h0);
        checkOutput("absd_swap_busy", 32'(busy_ok), 32'h1);
        checkOutput("absd_swap_ack_pulse", 32'(ack_after), 32'h0);

        applyStimulus(OP_ABSDIFF, 24'h123456, 24'h123456);
        checkOutput("absd_eq_lat", 32'(lat), 32'd4);
        checkOutput("absd_eq_z", 32'(z_ack), 32'h0);
        checkOutput("absd_eq_zero", 32'(zero_ack), 32'h1);
        checkOutput("absd_eq_swap", 32'(swap_ack), 32'h0);
        checkOutput("absd_eq_cout", 32'(cout_ack), 32'h1);

        // Reset lands in the SLICE cycle where the counter is 1.
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.OP  = OP_ADD;
        bus.A   = 24'h000100;
        bus.B   = 24'h000200;
        @(posedge CLK);
        #1;
        bus.REQ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        checkOutput("rst_mid_z", 32'(bus.Z), 32'h0);
        checkOutput("rst_mid_flags", {29'd0, bus.COUT, bus.SWAP, bus.ZERO}, 32'h0);
        checkOutput("rst_mid_busy", 32'(bus.BUSY), 32'h0);
        RSTN    = 1'b1;
        ack_any = bus.ACK;
        repeat (8) begin
            @(negedge CLK);
            ack_any = ack_any | bus.ACK;
        end
        checkOutput("rst_mid_no_ack", 32'(ack_any), 32'h0);

        applyStimulus(OP_ADD, 24'h000002, 24'h000003);
        checkOutput("post_rst_lat", 32'(lat), 32'd4);
        checkOutput("post_rst_z", 32'(z_ack), 32'h000005);

        // Single-slice instance, REQ held high: accepts in every IDLE cycle.
        @(negedge CLK);
        bus32.REQ = 1'b1;
        bus32.OP  = OP_ADD;
        bus32.A   = 32'h80000000;
        bus32.B   = 32'h80000000;
        @(posedge CLK);
        #1;
        bus32.OP  = 2'b11;
        bus32.A   = 32'h00000005;
        bus32.B   = 32'h00000007;
        ack_seen  = '0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            ack_seen[i] = bus32.ACK;
            if (i == 2) begin
                checkOutput("w32_ovf_z", bus32.Z, 32'h0);
                checkOutput("w32_ovf_cout", 32'(bus32.COUT), 32'h1);
                checkOutput("w32_ovf_zero", 32'(bus32.ZERO), 32'h1);
            end
            if (i == 3) checkOutput("w32_idle_gap", 32'(bus32.BUSY), 32'h0);
            if (i == 4) bus32.REQ = 1'b0;
            if (i == 5) begin
                checkOutput("w32_op11_z", bus32.Z, 32'h0000000C);
                checkOutput("w32_op11_cout", 32'(bus32.COUT), 32'h0);
            end
        end
        checkOutput("w32_ack_pattern", 32'(ack_seen), 32'h24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
